// File: rtl/act_word_unpacker_if.sv
// Packed-activation stream bundle: word input side plus per-lane output side.
// The unpacker connects through the slave modport; the driver/monitor uses master.
interface act_word_unpacker_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned CNT_W  = 3
);
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*LANE_W-1:0]    in_data;
    logic                       in_last;
    logic [CNT_W-1:0]           in_lanes;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANE_W-1:0]          out_data;
    logic [$clog2(LANES)-1:0]   out_lane;
    logic                       out_last;

    modport slave (
        input  in_valid, in_data, in_last, in_lanes, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last
    );

    modport master (
        output in_valid, in_data, in_last, in_lanes, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last
    );
endinterface

// File: rtl/act_word_unpacker.sv
// Serializes packed words of LANES activation lanes into one lane per output beat,
// with support for a short final word carrying fewer lanes.
module act_word_unpacker #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    act_word_unpacker_if.slave   bus,
    output logic                 busy
);
    localparam int unsigned IDX_W = $clog2(LANES);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                         state_q, state_d;
    logic [LANES-1:0][LANE_W-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [CNT_W-1:0]               n_q, n_d;
    logic                           lst_q, lst_d;

    logic                           at_end;
    logic                           in_ready;
    logic                           in_acc;
    logic                           out_acc;
    logic [CNT_W-1:0]               n_new;

    // Zero or out-of-range lane counts on a last word mean a full word.
    always_comb begin
        n_new = CNT_W'(LANES);
        if (bus.in_last && (bus.in_lanes != '0) && (bus.in_lanes <= CNT_W'(LANES)))
            n_new = bus.in_lanes;
    end

    assign at_end   = (CNT_W'(idx_q) == (n_q - CNT_W'(1)));
    // out_ready reaches in_ready combinationally so a new word loads with no bubble.
    assign in_ready = !rst && ((state_q == IDLE) ||
                               ((state_q == EMIT) && at_end && bus.out_ready));
    assign out_acc  = (state_q == EMIT) && bus.out_ready;
    assign in_acc   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        n_d     = n_q;
        lst_d   = lst_q;
        if (in_acc) begin
            state_d = EMIT;
            hold_d  = bus.in_data;
            idx_d   = '0;
            n_d     = n_new;
            lst_d   = bus.in_last;
        end else if (out_acc) begin
            if (at_end)
                state_d = IDLE;
            else
                idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            n_q     <= CNT_W'(LANES);
            lst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            lst_q   <= lst_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_data  = hold_q[idx_q];
    assign bus.out_lane  = idx_q;
    assign bus.out_last  = (state_q == EMIT) && lst_q && at_end;
    assign busy          = (state_q == EMIT);
endmodule

// File: tb/tb_act_word_unpacker.sv
// Directed and random checks of act_word_unpacker against a lane-queue reference.
module tb_act_word_unpacker;
    logic clk = 1'b0;
    logic rst;
    logic busy;

    act_word_unpacker_if #(.LANES(4), .LANE_W(8), .CNT_W(3)) bus ();

    act_word_unpacker #(.LANES(4), .LANE_W(8), .CNT_W(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [1:0] lane;
        logic       last;
    } beat_t;

    beat_t      q[$];
    logic [7:0] got_d[$];
    logic       got_l[$];
    int         checks = 0;
    int         errors = 0;
    logic       acc;
    logic [7:0] beat;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic [1:0] prev_lane;
    logic       prev_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each step drives inputs at the falling edge and samples 1ns later.
    task automatic step(input logic r, input logic v, input logic [31:0] d,
                        input logic l, input logic [2:0] nl, input logic ordy);
        int unsigned n;
        beat_t e;
        @(negedge clk);
        rst = r;
        bus.in_valid = v; bus.in_data = d; bus.in_last = l; bus.in_lanes = nl;
        bus.out_ready = ordy;
        #1;
        acc = 1'b0;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(!r && (q.size() == 0 || (q.size() == 1 && ordy))));
        if (prev_stall) begin
            chk("stall_data", 32'(bus.out_data), 32'(prev_d));
            chk("stall_lane", 32'(bus.out_lane), 32'(prev_lane));
            chk("stall_last", 32'(bus.out_last), 32'(prev_last));
        end
        if (bus.out_valid && ordy && q.size() != 0) begin
            e = q.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e.d));
            chk("out_lane", 32'(bus.out_lane), 32'(e.lane));
            chk("out_last", 32'(bus.out_last), 32'(e.last));
            got_d.push_back(bus.out_data);
            got_l.push_back(bus.out_last);
            beat = bus.out_data;
        end
        if (v && bus.in_ready && !r) begin
            n = (l && nl != 0 && nl <= 4) ? int'(nl) : 4;
            for (int unsigned i = 0; i < n; i++)
                q.push_back('{d[i*8 +: 8], 2'(i), l && (i == n - 1)});
            acc = 1'b1;
        end
        if (r) q.delete();
        prev_stall = bus.out_valid && !ordy && !r;
        prev_d = bus.out_data; prev_lane = bus.out_lane; prev_last = bus.out_last;
    endtask

    task automatic expect_seq(input string tag, input int unsigned n, input logic [7:0] e[8]);
        chk({tag, "_count"}, got_d.size(), n);
        for (int unsigned i = 0; i < n && i < got_d.size(); i++)
            chk(tag, 32'(got_d[i]), 32'(e[i]));
        got_d.delete();
        got_l.delete();
    endtask

    initial begin
        logic [7:0] e[8];
        logic       op[7];
        int         tries;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_lanes = '0;
        bus.out_ready = 1'b0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_lane", 32'(bus.out_lane), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);

        // Single full word
        got_d.delete(); got_l.delete();
        step(0, 1, 32'h44332211, 0, 0, 1);
        chk("single_acc", 32'(acc), 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        chk("single_idle_ready", 32'(bus.in_ready), 1);
        e = '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0};
        expect_seq("single", 4, e);

        // Back-to-back words, second accepted with the 0x04 beat
        step(0, 1, 32'h04030201, 0, 0, 1);
        tries = 0;
        do begin
            step(0, 1, 32'h08070605, 0, 0, 1);
            tries++;
        end while (!acc && tries < 10);
        chk("b2b_acc", 32'(acc), 1);
        chk("b2b_same_cycle", 32'(beat), 32'h04);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        expect_seq("b2b", 8, e);

        // Partial last word with two lanes
        step(0, 1, 32'hAABBCCDD, 1, 3'd2, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        chk("part2_last", (got_l.size() == 2) ? 32'(got_l[1]) : 32'hFFFF, 1);
        e = '{8'hDD, 8'hCC, 0, 0, 0, 0, 0, 0};
        expect_seq("part2", 2, e);

        // in_lanes 0 and 7 both mean a full word
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 32'hAABBCCDD, 1, (k == 0) ? 3'd0 : 3'd7, 1);
            for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
            chk("partfull_last", (got_l.size() == 4) ? 32'(got_l[3]) : 32'hFFFF, 1);
            e = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 0, 0, 0, 0};
            expect_seq("partfull", 4, e);
        end

        // Backpressure pattern
        op = '{1, 0, 0, 1, 1, 0, 1};
        step(0, 1, 32'h80FF7F01, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, op[i]);
        step(0, 0, 0, 0, 0, 1);
        e = '{8'h01, 8'h7F, 8'hFF, 8'h80, 0, 0, 0, 0};
        expect_seq("bp", 4, e);

        // Reset after two of four lanes
        step(0, 1, 32'h44332211, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(bus.in_ready), 1);
        got_d.delete(); got_l.delete();
        step(0, 1, 32'hDDCCBBAA, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 0, 0, 0};
        expect_seq("midrst", 4, e);

        // Random traffic against the lane-queue reference
        for (int i = 0; i < 600; i++)
            step(($urandom_range(99) == 0), ($urandom_range(2) != 0), $urandom(),
                 ($urandom_range(3) == 0), 3'($urandom_range(7)), ($urandom_range(3) != 0));
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
